// File: rtl/ext_pkg.sv
// Shared select codes, AES word stride and sequencer state type for the AES extension unit.
package ext_pkg;
  localparam logic [2:0] EXT_NONE    = 3'd0;
  localparam logic [2:0] EXT_AES_ENC = 3'd1;
  localparam logic [2:0] EXT_AES_DEC = 3'd2;
  localparam logic [2:0] EXT_XD2R    = 3'd3;
  localparam logic [2:0] EXT_R2XD    = 3'd4;

  localparam int AES_WORD_BYTES = 16;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} ext_seq_state_t;
endpackage

// File: rtl/ext_watchdog.sv
// Cycle counter for one outstanding engine job; o_expired flags the last allowed counted cycle.
// Zero latency on o_expired (combinational from the count); no backpressure.
module ext_watchdog #(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clear,
  input  logic i_count_en,
  output logic o_expired
);
  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [CNT_W-1:0] r_count;

  always_ff @(posedge clk) begin
    if (rst || i_clear) begin
      r_count <= '0;
    end else if (i_count_en) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_expired = i_count_en && (r_count == CNT_W'(TIMEOUT_CYCLES - 1));
endmodule

// File: rtl/ext_sequencer.sv
// Issues one AES engine job per 128-bit word, stalling the PC from the launch cycle until DONE.
// Best case 1 + 2N cycles for N words; eng_start holds until eng_ready, WAIT aborts after TIMEOUT_CYCLES.
module ext_sequencer
  import ext_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 64,
  parameter int ADDR_W         = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              exaluEnable,
  input  logic [2:0]        extensionModuleSelect,
  input  logic [11:0]       word_count,
  input  logic [ADDR_W-1:0] src_addr,
  input  logic [ADDR_W-1:0] dst_addr,
  output logic              stall,
  output logic              eng_start,
  output logic              eng_mode,
  output logic [ADDR_W-1:0] eng_src,
  output logic [ADDR_W-1:0] eng_dst,
  input  logic              eng_ready,
  input  logic              eng_done,
  output logic              seq_done,
  output logic              seq_err
);
  localparam logic [ADDR_W-1:0] STEP = ADDR_W'(AES_WORD_BYTES);

  ext_seq_state_t    r_state;
  ext_seq_state_t    w_next;
  logic [ADDR_W-1:0] r_src;
  logic [ADDR_W-1:0] r_dst;
  logic [11:0]       r_remaining;
  logic              r_mode;
  logic              r_err;

  logic w_launch;
  logic w_illegal;
  logic w_job_done;
  logic w_last;
  logic w_expired;
  logic w_timeout;

  assign w_launch   = (r_state == IDLE) && exaluEnable && (word_count != 12'd0) &&
                      ((extensionModuleSelect == EXT_AES_ENC) || (extensionModuleSelect == EXT_AES_DEC));
  assign w_illegal  = (r_state == IDLE) && exaluEnable && (extensionModuleSelect > EXT_R2XD);
  assign w_job_done = (r_state == WAIT) && eng_done;
  assign w_last     = w_job_done && (r_remaining == 12'd1);
  // A completing job in the expiry cycle takes priority over the abort.
  assign w_timeout  = (r_state == WAIT) && !eng_done && w_expired;

  ext_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk       (clk),
    .rst       (rst),
    .i_clear   (r_state != WAIT),
    .i_count_en(r_state == WAIT),
    .o_expired (w_expired)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_launch) w_next = ISSUE;
      ISSUE:   if (eng_ready) w_next = WAIT;
      WAIT: begin
        if (w_last || w_timeout) begin
          w_next = DONE;
        end else if (w_job_done) begin
          w_next = ISSUE;
        end
      end
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    stall     = w_launch || (r_state == ISSUE) || (r_state == WAIT);
    eng_start = (r_state == ISSUE);
    seq_done  = (r_state == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_src       <= '0;
      r_dst       <= '0;
      r_remaining <= '0;
      r_mode      <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      if (w_launch) begin
        r_src       <= src_addr;
        r_dst       <= dst_addr;
        r_remaining <= word_count;
        r_mode      <= (extensionModuleSelect == EXT_AES_DEC);
        r_err       <= 1'b0;
      end else if (w_illegal || w_timeout) begin
        r_err <= 1'b1;
      end
      if (w_job_done) begin
        r_src       <= r_src + STEP;
        r_dst       <= r_dst + STEP;
        r_remaining <= r_remaining - 12'd1;
      end
    end
  end

  assign eng_src  = r_src;
  assign eng_dst  = r_dst;
  assign eng_mode = r_mode;
  assign seq_err  = r_err;
endmodule

// File: tb/tb_ext_sequencer.sv
// Bench for ext_sequencer: job-level reference model checked every cycle, directed scenarios plus random traffic.
module tb_ext_sequencer;
  localparam int TO = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        exaluEnable;
  logic [2:0]  sel;
  logic [11:0] wc;
  logic [31:0] src;
  logic [31:0] dst;
  logic        eng_ready;
  logic        eng_done;
  logic        stall, eng_start, eng_mode, seq_done, seq_err;
  logic [31:0] eng_src, eng_dst;

  ext_sequencer #(.TIMEOUT_CYCLES(TO), .ADDR_W(32)) dut (
    .clk(clk), .rst(rst), .exaluEnable(exaluEnable), .extensionModuleSelect(sel),
    .word_count(wc), .src_addr(src), .dst_addr(dst), .stall(stall),
    .eng_start(eng_start), .eng_mode(eng_mode), .eng_src(eng_src), .eng_dst(eng_dst),
    .eng_ready(eng_ready), .eng_done(eng_done), .seq_done(seq_done), .seq_err(seq_err)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model: an instruction is a list of jobs; track which job is out and how long it has waited.
  bit          m_active = 0, m_accepted = 0, m_done_pulse = 0, m_err = 0, m_mode = 0;
  int          m_left = 0, m_wait = 0;
  logic [31:0] m_src = 0, m_dst = 0;

  // Bench-side engine: completes an accepted job after e_delay cycles, or never.
  bit e_pend = 0, e_never = 0, stray_en = 0;
  int e_cnt = 0, e_delay = 0;

  int          cyc, obs_stall, obs_start, obs_done, obs_done_at, obs_n;
  bit          obs_err_at_done;
  logic [31:0] obs_src[8];
  logic [31:0] obs_dst[8];
  logic        obs_mode[8];

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic clear_obs();
    cyc = 0; obs_stall = 0; obs_start = 0; obs_done = 0; obs_done_at = -1; obs_n = 0;
    obs_err_at_done = 0;
    for (int i = 0; i < 8; i++) begin
      obs_src[i] = 32'hDEADBEEF; obs_dst[i] = 32'hDEADBEEF; obs_mode[i] = 1'bx;
    end
  endtask

  function automatic bit m_launch();
    return !rst && !m_active && !m_done_pulse && exaluEnable && (sel == 3'd1 || sel == 3'd2) && wc != 12'd0;
  endfunction

  task automatic tick();
    bit exp_stall, exp_start, acc, launch;
    eng_done = (e_pend && e_cnt == 0) ||
               (stray_en && !(m_active && m_accepted) && $urandom_range(7) == 0);
    @(negedge clk);
    launch    = m_launch();
    exp_stall = launch || m_active;
    exp_start = m_active && !m_accepted;
    chk("stall", stall, exp_stall);
    chk("eng_start", eng_start, exp_start);
    chk("seq_done", seq_done, m_done_pulse);
    chk("seq_err", seq_err, m_err);
    chk("eng_mode", eng_mode, m_mode);
    chk("eng_src", eng_src, m_src);
    chk("eng_dst", eng_dst, m_dst);
    if (stall) obs_stall++;
    if (eng_start) obs_start++;
    if (eng_start && eng_ready && obs_n < 8) begin
      obs_src[obs_n] = eng_src; obs_dst[obs_n] = eng_dst; obs_mode[obs_n] = eng_mode; obs_n++;
    end
    if (seq_done) begin
      obs_done++; obs_done_at = cyc; obs_err_at_done = seq_err;
    end
    acc = exp_start && eng_ready;
    if (rst) begin
      m_active = 0; m_accepted = 0; m_done_pulse = 0; m_err = 0; m_mode = 0;
      m_left = 0; m_wait = 0; m_src = 0; m_dst = 0;
    end else if (m_done_pulse) begin
      m_done_pulse = 0;
    end else if (!m_active) begin
      if (launch) begin
        m_active = 1; m_accepted = 0; m_left = int'(wc); m_src = src; m_dst = dst;
        m_mode = (sel == 3'd2); m_err = 0;
      end else if (exaluEnable && sel >= 3'd5) begin
        m_err = 1;
      end
    end else if (!m_accepted) begin
      if (eng_ready) begin m_accepted = 1; m_wait = 0; end
    end else if (eng_done) begin
      m_left--; m_src += 32'd16; m_dst += 32'd16; m_accepted = 0;
      if (m_left == 0) begin m_active = 0; m_done_pulse = 1; end
    end else if (m_wait == TO - 1) begin
      m_err = 1; m_active = 0; m_accepted = 0; m_done_pulse = 1;
    end else begin
      m_wait++;
    end
    if (rst) begin
      e_pend = 0;
    end else begin
      if (e_pend) begin
        if (e_cnt == 0) e_pend = 0; else e_cnt--;
      end
      if (acc) begin e_pend = !e_never; e_cnt = e_delay; end
    end
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic launch_instr(input logic [2:0] s, input logic [11:0] n, input logic [31:0] a, input logic [31:0] b);
    exaluEnable = 1; sel = s; wc = n; src = a; dst = b;
    clear_obs();
    tick();
    exaluEnable = 0; sel = 3'd0;
  endtask

  task automatic run_done(input string nm, input int bound);
    int n = 0;
    while (obs_done == 0 && n < bound) begin tick(); n++; end
    chk({nm, "_finished"}, obs_done != 0, 1);
  endtask

  initial begin
    rst = 1; exaluEnable = 0; sel = 0; wc = 0; src = 0; dst = 0; eng_ready = 0; eng_done = 0;
    clear_obs();
    repeat (2) @(posedge clk);
    #1;
    tick(); tick();
    rst = 0;
    chk("rst_stall", stall, 0);
    chk("rst_start", eng_start, 0);
    chk("rst_err", seq_err, 0);
    chk("rst_src", eng_src, 0);

    // Encrypt two words, engine done 3 cycles after accept
    eng_ready = 1; e_delay = 2; e_never = 0;
    launch_instr(3'd1, 12'd2, 32'h100, 32'h200);
    run_done("t1", 60);
    chk("t1_jobs", obs_n, 2);
    chk("t1_src0", obs_src[0], 32'h100);
    chk("t1_dst0", obs_dst[0], 32'h200);
    chk("t1_src1", obs_src[1], 32'h110);
    chk("t1_dst1", obs_dst[1], 32'h210);
    chk("t1_mode", obs_mode[0], 0);
    chk("t1_stall_cycles", obs_stall, 9);
    chk("t1_done_at", obs_done_at, 9);
    tick();
    chk("t1_done_once", obs_done, 1);

    // Decrypt one word with ready held low for 5 cycles
    eng_ready = 0; e_delay = 0;
    launch_instr(3'd2, 12'd1, 32'h3000, 32'h4000);
    repeat (5) tick();
    eng_ready = 1;
    run_done("t2", 30);
    chk("t2_start_cycles", obs_start, 6);
    chk("t2_src0", obs_src[0], 32'h3000);
    chk("t2_mode", obs_mode[0], 1);
    chk("t2_done_at", obs_done_at, 8);
    chk("t2_err", obs_err_at_done, 0);

    // Pass-through selects, zero count, then illegal select
    clear_obs();
    exaluEnable = 1; wc = 12'd5; src = 32'h10; dst = 32'h20;
    sel = 3'd3; tick();
    sel = 3'd4; tick();
    sel = 3'd0; tick();
    sel = 3'd1; wc = 12'd0; tick();
    exaluEnable = 0; tick(); tick();
    chk("t3_stall", obs_stall, 0);
    chk("t3_start", obs_start, 0);
    chk("t3_done", obs_done, 0);
    exaluEnable = 1; sel = 3'd6; wc = 12'd2; tick();
    exaluEnable = 0; sel = 3'd0;
    chk("t3_illegal_err", seq_err, 1);
    chk("t3_illegal_stall", obs_stall, 0);

    // Engine never completes: watchdog abort, then next launch clears the error
    eng_ready = 1; e_never = 1;
    launch_instr(3'd1, 12'd2, 32'h500, 32'h600);
    run_done("t4", 40);
    chk("t4_done_at", obs_done_at, 10);
    chk("t4_stall_cycles", obs_stall, 10);
    chk("t4_err", obs_err_at_done, 1);
    chk("t4_jobs", obs_n, 1);
    e_never = 0; e_delay = 0;
    launch_instr(3'd1, 12'd1, 32'h700, 32'h800);
    chk("t4_err_cleared", seq_err, 0);
    run_done("t4b", 20);

    // Address wrap with zero-latency engine
    launch_instr(3'd1, 12'd3, 32'hFFFF_FFF0, 32'hFFFF_FFE0);
    run_done("t5", 40);
    chk("t5_src0", obs_src[0], 32'hFFFF_FFF0);
    chk("t5_src1", obs_src[1], 32'h0000_0000);
    chk("t5_src2", obs_src[2], 32'h0000_0010);
    chk("t5_dst0", obs_dst[0], 32'hFFFF_FFE0);
    chk("t5_dst1", obs_dst[1], 32'hFFFF_FFF0);
    chk("t5_dst2", obs_dst[2], 32'h0000_0000);
    chk("t5_stall_cycles", obs_stall, 7);
    chk("t5_done_at", obs_done_at, 7);

    // Reset during WAIT of job 2 of 4, then a clean relaunch
    e_delay = 3;
    launch_instr(3'd1, 12'd4, 32'h800, 32'h900);
    begin
      int n = 0;
      while (obs_n < 2 && n < 40) begin tick(); n++; end
    end
    chk("t6_reached_job2", obs_n, 2);
    rst = 1; tick(); rst = 0;
    chk("t6_stall", stall, 0);
    chk("t6_start", eng_start, 0);
    chk("t6_done", seq_done, 0);
    chk("t6_src", eng_src, 0);
    e_delay = 1;
    launch_instr(3'd1, 12'd4, 32'h1000, 32'h2000);
    run_done("t6", 60);
    chk("t6_jobs", obs_n, 4);
    chk("t6_src3", obs_src[3], 32'h1030);
    chk("t6_dst3", obs_dst[3], 32'h2030);
    tick();
    chk("t6_done_once", obs_done, 1);

    // Random traffic against the model
    stray_en = 1;
    for (int i = 0; i < 4000; i++) begin
      int r;
      rst = ($urandom_range(299) == 0);
      exaluEnable = !rst && ($urandom_range(2) != 0);
      r = int'($urandom_range(9));
      sel = (r < 4) ? 3'd1 : (r < 7) ? 3'd2 : 3'($urandom_range(7));
      wc = 12'($urandom_range(4));
      src = ($urandom_range(3) == 0) ? (32'hFFFF_FFC0 + 32'($urandom_range(63))) : $urandom;
      dst = $urandom;
      eng_ready = ($urandom_range(3) != 0);
      e_delay = int'($urandom_range(5));
      e_never = ($urandom_range(19) == 0);
      tick();
    end
    rst = 0; exaluEnable = 0; stray_en = 0;
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/ext_sequencer.md
# ext_sequencer

Multi-cycle sequencer for the AES-128 extension unit. When the decoder flags an extension instruction selecting encrypt or decrypt, this block stalls the PC and issues one engine job per 128-bit AES word. Per job it supplies source and destination byte addresses, steps them by 16 bytes, and counts down the immediate word count. It sits between the instruction decoder and the AES engine, and gates the core's PC write enable. XD2R/R2XD moves, and select 0, pass through without sequencing.

## Interface
Parameters:
- TIMEOUT_CYCLES, 64: maximum cycles a job waits in WAIT for eng_done before aborting.
- ADDR_W, 32: byte-address width.

Ports:
- clk  in  1  core clock
- rst  in  1  reset; synchronous, active-high
- exaluEnable  in  1  decoded extension instruction present this cycle
- extensionModuleSelect  in  3  1 = encrypt, 2 = decrypt, 3 = XD2R, 4 = R2XD, 0 = disable, 5–7 = illegal
- word_count  in  12  imm[11:0]; number of AES words
- src_addr  in  ADDR_W  rs1 value; first source address
- dst_addr  in  ADDR_W  rd value; first destination address
- stall  out  1  high holds the PC; the core uses pcWE & ~stall
- eng_start  out  1  job request; held until accepted
- eng_mode  out  1  0 = encrypt, 1 = decrypt
- eng_src  out  ADDR_W  current job source address
- eng_dst  out  ADDR_W  current job destination address
- eng_ready  in  1  engine accepts the job when eng_start & eng_ready
- eng_done  in  1  one-cycle pulse; the accepted job has completed
- seq_done  out  1  one-cycle pulse; the whole instruction has completed
- seq_err  out  1  sticky; set on timeout or illegal select, cleared at the next launch

## Operation
- A launch occurs when the state is IDLE, exaluEnable = 1, select is 1 or 2, and word_count ≠ 0.
  - On launch the block latches src, dst, word_count and mode (sel == 2), clears seq_err, and moves to ISSUE.
- Non-launch cases in IDLE:
  - word_count = 0 with select 1 or 2: no-op. No stall, no seq_done.
  - Select 0, 3 or 4: ignored. No stall.
  - Select 5–7 with exaluEnable: sets seq_err. No stall.
- States:
  - IDLE → ISSUE on launch.
  - ISSUE: eng_start = 1, addresses stable. → WAIT when eng_ready = 1. Without eng_ready, it holds indefinitely; no timeout in ISSUE.
  - WAIT: the watchdog counts cycles.
    - On eng_done: remaining −= 1, src += 16, dst += 16.
    - If remaining becomes 0 → DONE; otherwise → ISSUE.
    - If the watchdog reaches TIMEOUT_CYCLES before eng_done: set seq_err → DONE.
  - DONE: seq_done = 1, stall = 0, exaluEnable ignored → IDLE. The PC advances during this cycle, so the same instruction never relaunches.
- stall = launch | (state ∈ {ISSUE, WAIT}). stall is combinational from IDLE so the launching instruction holds in its own cycle.
- Address arithmetic is modulo 2^ADDR_W; wrap is silent.
- An eng_done arriving outside WAIT is ignored.
- Reset values: state IDLE; stall, eng_start, eng_mode, seq_done and seq_err = 0; eng_src, eng_dst, remaining and watchdog = 0.
- Reset mid-operation:
  - The block is in IDLE the next cycle with all outputs at reset values.
  - The engine shares rst; no partial-job cleanup is done.

## Timing
- Launch cycle T0: stall = 1. T1: ISSUE, eng_start = 1.
- Best case per word: 1 cycle in ISSUE (ready already high) + 1 cycle in WAIT (eng_done in the first WAIT cycle).
- For word_count = N with zero-latency engine handshakes: stall is high for 1 + 2N cycles, and seq_done is asserted in cycle 1 + 2N.
- eng_src, eng_dst and eng_mode are registered. They change only on the eng_done transition out of WAIT.
- The watchdog resets on each entry to WAIT.
- The timeout fires in the WAIT cycle where the count equals TIMEOUT_CYCLES − 1 with no eng_done.
- eng_done in that same cycle wins over the timeout.

## Structure
- Shared package ext_pkg holds:
  - select constants EXT_NONE, EXT_AES_ENC, EXT_AES_DEC, EXT_XD2R, EXT_R2XD;
  - AES_WORD_BYTES = 16;
  - typedef enum logic [1:0] ext_seq_state_t {IDLE, ISSUE, WAIT, DONE}.
- One sub-module, ext_watchdog: clear input, count-enable input, expired output, width $clog2(TIMEOUT_CYCLES).

## Test plan
- Encrypt, count = 2, src = 0x100, dst = 0x200, ready = 1, done 3 cycles after accept:
  - two starts with (0x100, 0x200) then (0x110, 0x210), eng_mode = 0;
  - stall continuous until DONE; seq_done exactly once.
- Decrypt, count = 1, eng_ready low for 5 cycles:
  - eng_start and addresses held stable for 5 cycles; eng_mode = 1; no timeout.
- Select 3, 4 and 0, and encrypt with count = 0:
  - stall = 0, eng_start = 0, seq_done = 0.
  - Select 6: seq_err = 1, no stall.
- eng_done never asserted, TIMEOUT_CYCLES = 8:
  - seq_err = 1 after 8 WAIT cycles, then DONE with seq_done = 1, stall drops.
  - seq_err is cleared by the next launch.
- src = 0xFFFFFFF0, dst = 0xFFFFFFE0, count = 3:
  - job sources 0xFFFFFFF0, 0x00000000, 0x00000010;
  - job destinations 0xFFFFFFE0, 0xFFFFFFF0, 0x00000000.
- rst asserted during WAIT of job 2 of 4:
  - the next cycle has stall = 0, eng_start = 0, seq_done = 0, state IDLE;
  - a fresh launch then runs all words correctly.
